// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding, opcodes,
// ALU operation / operand-B encodings and the packed control word.
// Build option: ILLEGAL_TRAP_EN selects trap-on-unknown-opcode behaviour.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EX_R   = 4'd3,
    S_EX_I   = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_TRAP   = 4'd11
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_RFN = 2'b10;
  localparam logic [1:0] ALU_IFN = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // All datapath controls produced by the sequencer in one word.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LD) ||
           (op == OP_SD) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the sequencer (master) and the datapath (slave).
interface multicycle_control_if;
  logic [6:0] instr_op_i;
  logic       mem_ready_i;
  logic       PCWrite_o;
  logic       PCWriteCond_o;
  logic       PCSource_o;
  logic       IorD_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       IRWrite_o;
  logic       MemtoReg_o;
  logic       RegWrite_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [1:0] ALU_op_o;
  logic       retire_o;
  logic [3:0] state_o;

  modport master (
    input  instr_op_i, mem_ready_i,
    output PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o, MemRead_o,
           MemWrite_o, IRWrite_o, MemtoReg_o, RegWrite_o, ALUSrcA_o,
           ALUSrcB_o, ALU_op_o, retire_o, state_o
  );

  modport slave (
    output instr_op_i, mem_ready_i,
    input  PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o, MemRead_o,
           MemWrite_o, IRWrite_o, MemtoReg_o, RegWrite_o, ALUSrcA_o,
           ALUSrcB_o, ALU_op_o, retire_o, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational map from current state (plus memory ready and the
// illegal-opcode flag) to the datapath control word.
module multicycle_ctrl_decode
  import multicycle_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   illegal_i,
  output ctrl_t  ctrl_o
);

  // Every control defaults to 0; each state raises only what it needs.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        // IR and PC only load on the cycle the instruction word arrives.
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
        // Without trapping, an unknown opcode retires here as a NOP.
        ctrl_o.retire    = illegal_i & ~TRAP_EN;
      end
      S_EX_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RS2;
        ctrl_o.alu_op    = ALU_RFN;
      end
      S_EX_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_IFN;
      end
      S_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.retire    = mem_ready_i;
      end
      S_WB_ALU: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_RS2;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = 1'b1;
        ctrl_o.retire        = 1'b1;
      end
      default: ctrl_o = '0;  // IDLE and TRAP drive nothing
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer top: state register and next-state logic; controls
// come from multicycle_ctrl_decode. Outputs are a pure function of the state
// register (gated by mem_ready_i where a request completes), so the async
// reset removes any pending memory request immediately.
// Build option: ILLEGAL_TRAP_EN -- unknown opcodes park the FSM in TRAP.
module multicycle_control
  import multicycle_pkg::*;
(
  input logic                 clk_i,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

  state_e state_q;
  ctrl_t  ctrl;
  logic   illegal;

  assign illegal = ~op_is_legal(bus.instr_op_i);

  // FSM state register with next-state selection.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH:  if (bus.mem_ready_i) state_q <= S_DECODE;
        S_DECODE: begin
          case (bus.instr_op_i)
            OP_R:         state_q <= S_EX_R;
            OP_I:         state_q <= S_EX_I;
            OP_LD, OP_SD: state_q <= S_ADDR;
            OP_BEQ:       state_q <= S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
            default:      state_q <= S_TRAP;
`else
            default:      state_q <= S_FETCH;
`endif
          endcase
        end
        S_EX_R:   state_q <= S_WB_ALU;
        S_EX_I:   state_q <= S_WB_ALU;
        // Opcode is held stable, so it still tells ld from sd here.
        S_ADDR:   state_q <= (bus.instr_op_i == OP_LD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: if (bus.mem_ready_i) state_q <= S_WB_MEM;
        S_MEM_WR: if (bus.mem_ready_i) state_q <= S_FETCH;
        S_WB_ALU: state_q <= S_FETCH;
        S_WB_MEM: state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:   state_q <= S_TRAP;
`else
        S_TRAP:   state_q <= S_IDLE;
`endif
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  multicycle_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (bus.mem_ready_i),
    .illegal_i   (illegal),
    .ctrl_o      (ctrl)
  );

  assign bus.PCWrite_o     = ctrl.pc_write;
  assign bus.PCWriteCond_o = ctrl.pc_write_cond;
  assign bus.PCSource_o    = ctrl.pc_source;
  assign bus.IorD_o        = ctrl.i_or_d;
  assign bus.MemRead_o     = ctrl.mem_read;
  assign bus.MemWrite_o    = ctrl.mem_write;
  assign bus.IRWrite_o     = ctrl.ir_write;
  assign bus.MemtoReg_o    = ctrl.mem_to_reg;
  assign bus.RegWrite_o    = ctrl.reg_write;
  assign bus.ALUSrcA_o     = ctrl.alu_src_a;
  assign bus.ALUSrcB_o     = ctrl.alu_src_b;
  assign bus.ALU_op_o      = ctrl.alu_op;
  assign bus.retire_o      = ctrl.retire;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: one row per clock cycle with
// hand-computed state and control word, plus hand sequences for trap
// persistence and reset during a pending store.
module tb_multicycle_control;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] SD  = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [14:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  // Packs control values in a fixed bit order for comparison.
  function automatic logic [14:0] cw(input logic pcw, pcwc, pcs, iord, mr, mw,
                                     irw, m2r, rw, a, input logic [1:0] b,
                                     input logic [1:0] aop, input logic ret);
    return {pcw, pcwc, pcs, iord, mr, mw, irw, m2r, rw, a, b, aop, ret};
  endfunction

  function automatic logic [14:0] actual_cw();
    return cw(bus.PCWrite_o, bus.PCWriteCond_o, bus.PCSource_o, bus.IorD_o,
              bus.MemRead_o, bus.MemWrite_o, bus.IRWrite_o, bus.MemtoReg_o,
              bus.RegWrite_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALU_op_o,
              bus.retire_o);
  endfunction

  task automatic check_row(input string tag, input int idx,
                           input logic [3:0] st, input logic [14:0] ctl);
    checks++;
    if (bus.state_o !== st) begin
      errors++;
      $display("FAIL %s[%0d] state: got %0d expected %0d", tag, idx, bus.state_o, st);
    end
    checks++;
    if (actual_cw() !== ctl) begin
      errors++;
      $display("FAIL %s[%0d] ctrl: got %015b expected %015b", tag, idx, actual_cw(), ctl);
    end
  endtask

  logic [14:0] w_idle, w_f1, w_f0, w_dec, w_dnop, w_exr, w_exi, w_addr;
  logic [14:0] w_mrd, w_mw1, w_mw0, w_wba, w_wbm, w_br;

  initial begin
    //            pcw pcwc pcs iord mr mw irw m2r rw a  b      aop   ret
    w_idle = '0;
    w_f1   = cw(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b01, 2'b00, 0);
    w_f0   = cw(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0);
    w_dec  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0);
    w_dnop = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 1);
    w_exr  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0);
    w_exi  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b11, 0);
    w_addr = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0);
    w_mrd  = cw(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    w_mw1  = cw(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    w_mw0  = cw(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    w_wba  = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1);
    w_wbm  = cw(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1);
    w_br   = cw(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1);

    // R-type from reset release: IDLE, FETCH, DECODE, EX_R, WB_ALU
    vecs.push_back('{R, 1'b1, 4'd0, w_idle});
    vecs.push_back('{R, 1'b1, 4'd1, w_f1});
    vecs.push_back('{R, 1'b1, 4'd2, w_dec});
    vecs.push_back('{R, 1'b1, 4'd3, w_exr});
    vecs.push_back('{R, 1'b1, 4'd8, w_wba});
    // I-type; ready low outside memory states must be ignored
    vecs.push_back('{I, 1'b1, 4'd1, w_f1});
    vecs.push_back('{I, 1'b0, 4'd2, w_dec});
    vecs.push_back('{I, 1'b0, 4'd4, w_exi});
    vecs.push_back('{I, 1'b0, 4'd8, w_wba});
    // sd, zero wait
    vecs.push_back('{SD, 1'b1, 4'd1, w_f1});
    vecs.push_back('{SD, 1'b1, 4'd2, w_dec});
    vecs.push_back('{SD, 1'b1, 4'd5, w_addr});
    vecs.push_back('{SD, 1'b1, 4'd7, w_mw1});
    // beq with one fetch wait
    vecs.push_back('{BEQ, 1'b0, 4'd1, w_f0});
    vecs.push_back('{BEQ, 1'b1, 4'd1, w_f1});
    vecs.push_back('{BEQ, 1'b1, 4'd2, w_dec});
    vecs.push_back('{BEQ, 1'b1, 4'd10, w_br});
    // ld with two wait cycles in MEM_RD: 7 cycles from FETCH
    vecs.push_back('{LD, 1'b1, 4'd1, w_f1});
    vecs.push_back('{LD, 1'b1, 4'd2, w_dec});
    vecs.push_back('{LD, 1'b1, 4'd5, w_addr});
    vecs.push_back('{LD, 1'b0, 4'd6, w_mrd});
    vecs.push_back('{LD, 1'b0, 4'd6, w_mrd});
    vecs.push_back('{LD, 1'b1, 4'd6, w_mrd});
    vecs.push_back('{LD, 1'b1, 4'd9, w_wbm});
    // unknown opcode
    vecs.push_back('{BAD, 1'b1, 4'd1, w_f1});
`ifdef ILLEGAL_TRAP_EN
    vecs.push_back('{BAD, 1'b1, 4'd2, w_dec});
`else
    vecs.push_back('{BAD, 1'b1, 4'd2, w_dnop});
    vecs.push_back('{R, 1'b1, 4'd1, w_f1});
`endif

    bus.instr_op_i  = 7'd0;
    bus.mem_ready_i = 1'b0;

    // Reset held: IDLE with all controls low
    repeat (2) @(negedge clk_i);
    #1 check_row("reset", 0, 4'd0, w_idle);
    @(negedge clk_i);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      bus.instr_op_i  = vecs[k].op;
      bus.mem_ready_i = vecs[k].rdy;
      #1 check_row("vec", k, vecs[k].st, vecs[k].ctl);
      $display("vec %0d op=%07b rdy=%0b state=%0d ctrl=%015b", k,
               vecs[k].op, vecs[k].rdy, bus.state_o, actual_cw());
      @(negedge clk_i);
    end

`ifdef ILLEGAL_TRAP_EN
    // TRAP persists regardless of inputs
    for (int t = 0; t < 20; t++) begin
      bus.instr_op_i  = (t % 2 == 0) ? R : BAD;
      bus.mem_ready_i = t[0];
      #1 check_row("trap", t, 4'd11, w_idle);
      @(negedge clk_i);
    end
`endif

    // Clean reset pulse, then sd stalled in MEM_WR with reset mid-cycle
    rst_n = 1'b0;
    #1 check_row("rstpulse", 0, 4'd0, w_idle);
    @(negedge clk_i);
    rst_n = 1'b1;
    bus.instr_op_i  = SD;
    bus.mem_ready_i = 1'b1;
    #1 check_row("sdrst", 0, 4'd0, w_idle);
    @(negedge clk_i);
    #1 check_row("sdrst", 1, 4'd1, w_f1);
    @(negedge clk_i);
    bus.mem_ready_i = 1'b0;
    #1 check_row("sdrst", 2, 4'd2, w_dec);
    @(negedge clk_i);
    #1 check_row("sdrst", 3, 4'd5, w_addr);
    @(negedge clk_i);
    #1 check_row("sdrst", 4, 4'd7, w_mw0);
    @(negedge clk_i);
    #1 check_row("sdrst", 5, 4'd7, w_mw0);
    #2 rst_n = 1'b0;
    #1 check_row("sdrst", 6, 4'd0, w_idle);
    $display("sdrst reset mid MEM_WR: MemWrite=%0b state=%0d", bus.MemWrite_o, bus.state_o);
    @(negedge clk_i);
    rst_n = 1'b1;
    bus.mem_ready_i = 1'b1;
    #1 check_row("sdrst", 7, 4'd0, w_idle);
    @(negedge clk_i);
    #1 check_row("sdrst", 8, 4'd1, w_f1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
